// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
// The field polynomial is x^8 + x^4 + x^3 + x + 1 (0x11B).
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    localparam byte_t GF_REDUCE = 8'h1B;

    // Leftmost coefficient row of each matrix; the other rows are rotations of it.
    // Each coefficient is a bit mask over {x8, x4, x2, x1}.
    localparam logic [3:0] FWD_ROW [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0] INV_ROW [4] = '{4'hE, 4'hB, 4'hD, 4'h9};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// Every constant product is an XOR of the x1/x2/x4/x8 xtime chain.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic    [31:0] col_in,
    input  logic           inverse,
    output logic    [31:0] col_out
);

    function automatic byte_t mulc(input byte_t b, input logic [3:0] c);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    byte_t in_b  [4];
    byte_t out_b [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            in_b[r] = col_in[31 - 8*r -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            out_b[r] = 8'h00;
            // Row r weights input byte (r+j) mod 4 with row0 coefficient j.
            for (int j = 0; j < 4; j++) begin
                out_b[r] = out_b[r] ^
                    mulc(in_b[(r + j) % 4], inverse ? INV_ROW[j] : FWD_ROW[j]);
            end
        end
        col_out = {out_b[0], out_b[1], out_b[2], out_b[3]};
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle MixColumns / InvMixColumns over a 128-bit state,
// transforming COLS_PER_CYCLE columns of the work register in place per clock.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            inverse,
    input  logic [127:0]    state_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    state_out,
    output logic            busy,
    output mc_state_t       dbg_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);
    localparam logic [2:0] LAST = 3'(4 - COLS_PER_CYCLE);

    mc_state_t    state_q;
    logic [2:0]   col_cnt_q;
    logic         mode_q;
    state_t       work_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [1:0]   idx     [COLS_PER_CYCLE];
    column_t      col_in  [COLS_PER_CYCLE];
    column_t      col_out [COLS_PER_CYCLE];

    // Handshake: a state transfers on a rising edge where in_valid & in_ready;
    // a result leaves on a rising edge where out_valid & out_ready. in_valid and
    // state_in/inverse are ignored whenever in_ready is low, and state_out is
    // held while out_valid is high and out_ready is low.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = work_q;
    assign dbg_state = state_q;

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        // Column c occupies work_q[127-32c -: 32], i.e. slot (3-c) from the LSB end.
        assign idx[i]    = col_cnt_q[1:0] + 2'(i);
        assign col_in[i] = work_q[{2'd3 - idx[i], 5'b0} +: 32];

        mix_column_unit u_mcu (
            .col_in  (col_in[i]),
            .inverse (mode_q),
            .col_out (col_out[i])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= 3'd0;
            mode_q      <= 1'b0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q    <= state_in;
                        mode_q    <= inverse;
                        col_cnt_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        work_q[{2'd3 - idx[i], 5'b0} +: 32] <= col_out[i];
                    end
                    col_cnt_q <= col_cnt_q + STEP;
                    if (col_cnt_q == LAST) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q    <= state_in;
                            mode_q    <= inverse;
                            col_cnt_q <= 3'd0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
